// File: rtl/rv_pkg.sv
// Shared RV32I definitions: opcode constants, the canonical NOP and the fetch FSM state type.
package rv_pkg;

  localparam int unsigned XLEN_DEFAULT = 32;

  localparam logic [6:0]  OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0]  OPC_OP     = 7'b0110011;
  localparam logic [6:0]  OPC_LUI    = 7'b0110111;

  localparam logic [31:0] NOP_INSN   = 32'h0000_0013;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/imm_gen.sv
// Immediate generator: I-type and U-type immediates from a raw instruction word.
module imm_gen
  import rv_pkg::*;
(
  input  logic [31:0] ir,
  output logic [31:0] imm_i,
  output logic [31:0] imm_u
);

  always_comb begin
    imm_i = {{20{ir[31]}}, ir[31:20]};
    imm_u = {ir[31:12], 12'b0};
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction-fetch responder: owns PC/IR, runs the imem req/gnt/rvalid handshake
// with a WAIT timeout, and exposes decoded instruction fields to the control unit.
module instr_fetch_unit
  import rv_pkg::*;
#(
  parameter int unsigned XLEN     = 32,
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned TIMEOUT  = 15
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            fetch_req,
  output logic            busy,
  output logic            fetch_done,
  output logic            fetch_err,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] ir,
  output logic [6:0]      opcode,
  output logic [2:0]      funct3,
  output logic [6:0]      funct7,
  output logic [4:0]      rd,
  output logic [4:0]      rs1,
  output logic [4:0]      rs2,
  output logic [XLEN-1:0] imm_i,
  output logic [XLEN-1:0] imm_u
);

  localparam int unsigned CNT_W    = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  fetch_state_e     state_q, state_d;
  logic [XLEN-1:0]  pc_q, pc_d;
  logic [XLEN-1:0]  ir_q, ir_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             done_q, done_d;
  logic             err_q, err_d;

  // State and data registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      ir_q    <= NOP_INSN;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  // Next-state logic; rvalid only matters in WAIT, so late responses fall on the floor
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (fetch_req) state_d = REQ;
      end
      REQ: begin
        if (imem_gnt) begin
          state_d = WAIT;
          cnt_d   = '0;
        end
      end
      WAIT: begin
        if (imem_rvalid) begin
          ir_d    = imem_rdata;
          pc_d    = pc_q + XLEN'(4);
          done_d  = 1'b1;
          state_d = IDLE;
        end else if (cnt_q == CNT_LAST) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d   = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy       = (state_q != IDLE);
  assign imem_req   = (state_q == REQ);
  assign imem_addr  = pc_q;
  assign fetch_done = done_q;
  assign fetch_err  = err_q;
  assign pc         = pc_q;
  assign ir         = ir_q;

  assign opcode = ir_q[6:0];
  assign rd     = ir_q[11:7];
  assign funct3 = ir_q[14:12];
  assign rs1    = ir_q[19:15];
  assign rs2    = ir_q[24:20];
  assign funct7 = ir_q[31:25];

  imm_gen u_imm_gen (
    .ir    (ir_q),
    .imm_i (imm_i),
    .imm_u (imm_u)
  );

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit: two instances (RESET_PC 0 and wrap-around)
// share stimulus; expected IR words are queued on rvalid and retired on fetch_done.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        fetch_req, imem_gnt, imem_rvalid;
  logic [31:0] imem_rdata;

  logic        busy_a, done_a, err_a, req_a;
  logic [31:0] addr_a, pc_a, ir_a, imm_i_a, imm_u_a;
  logic [6:0]  opcode_a, funct7_a;
  logic [2:0]  funct3_a;
  logic [4:0]  rd_a, rs1_a, rs2_a;

  logic        busy_w, done_w, err_w, req_w;
  logic [31:0] addr_w, pc_w, ir_w, imm_i_w, imm_u_w;
  logic [6:0]  opcode_w, funct7_w;
  logic [2:0]  funct3_w;
  logic [4:0]  rd_w, rs1_w, rs2_w;

  int errors = 0;
  int checks = 0;
  logic [31:0] exp_ir_q[$];
  logic [31:0] exp_pc_a, exp_pc_w;

  always #5 clk = ~clk;

  instr_fetch_unit #(.XLEN(32), .RESET_PC(32'h0000_0000), .TIMEOUT(15)) dut (
    .clk(clk), .rst_n(rst_n), .fetch_req(fetch_req), .busy(busy_a),
    .fetch_done(done_a), .fetch_err(err_a), .imem_req(req_a), .imem_addr(addr_a),
    .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .pc(pc_a), .ir(ir_a), .opcode(opcode_a), .funct3(funct3_a), .funct7(funct7_a),
    .rd(rd_a), .rs1(rs1_a), .rs2(rs2_a), .imm_i(imm_i_a), .imm_u(imm_u_a)
  );

  instr_fetch_unit #(.XLEN(32), .RESET_PC(32'hFFFF_FFFC), .TIMEOUT(15)) dut_w (
    .clk(clk), .rst_n(rst_n), .fetch_req(fetch_req), .busy(busy_w),
    .fetch_done(done_w), .fetch_err(err_w), .imem_req(req_w), .imem_addr(addr_w),
    .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .pc(pc_w), .ir(ir_w), .opcode(opcode_w), .funct3(funct3_w), .funct7(funct7_w),
    .rd(rd_w), .rs1(rs1_w), .rs2(rs2_w), .imm_i(imm_i_w), .imm_u(imm_u_w)
  );

  // Retire scoreboard entries on every completed fetch
  always @(negedge clk) begin
    if (rst_n === 1'b1 && (done_a === 1'b1 || done_w === 1'b1)) begin
      logic [31:0] e;
      checks++;
      if (exp_ir_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_done: done_a=%b done_w=%b with empty scoreboard", done_a, done_w);
      end else begin
        e = exp_ir_q.pop_front();
        exp_pc_a = exp_pc_a + 32'd4;
        exp_pc_w = exp_pc_w + 32'd4;
        if (ir_a !== e || ir_w !== e || pc_a !== exp_pc_a || pc_w !== exp_pc_w ||
            done_a !== 1'b1 || done_w !== 1'b1 || err_a !== 1'b0) begin
          errors++;
          $display("FAIL sb_retire: ir_a=%h ir_w=%h pc_a=%h pc_w=%h done=%b/%b err=%b, expected ir=%h pc_a=%h pc_w=%h",
                   ir_a, ir_w, pc_a, pc_w, done_a, done_w, err_a, e, exp_pc_a, exp_pc_w);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, observed time %0t required end before", $time);
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n    = 1'b1;
    exp_pc_a = 32'h0000_0000;
    exp_pc_w = 32'hFFFF_FFFC;
    exp_ir_q.delete();
    @(negedge clk);
  endtask

  // One fetch: gnt after gnt_dly stall cycles, rvalid after rv_dly idle WAIT cycles
  task automatic do_fetch(input int gnt_dly, input int rv_dly, input logic [31:0] data);
    logic [31:0] addr0;
    int req_cyc;
    fetch_req = 1'b1;
    @(negedge clk);
    fetch_req = 1'b0;
    addr0   = addr_a;
    req_cyc = 0;
    checks++;
    if (addr0 !== exp_pc_a) begin
      errors++;
      $display("FAIL req_addr: imem_addr=%h expected %h", addr0, exp_pc_a);
    end
    for (int i = 0; i < gnt_dly; i++) begin
      if (req_a === 1'b1) req_cyc++;
      checks++;
      if (addr_a !== addr0 || busy_a !== 1'b1) begin
        errors++;
        $display("FAIL req_stable: addr=%h busy=%b expected addr=%h busy=1", addr_a, busy_a, addr0);
      end
      @(negedge clk);
    end
    if (req_a === 1'b1) req_cyc++;
    imem_gnt = 1'b1;
    @(negedge clk);
    imem_gnt = 1'b0;
    checks++;
    if (req_cyc != gnt_dly + 1) begin
      errors++;
      $display("FAIL req_cycles: imem_req high %0d cycles, expected %0d", req_cyc, gnt_dly + 1);
    end
    checks++;
    if (req_a !== 1'b0 || busy_a !== 1'b1) begin
      errors++;
      $display("FAIL wait_entry: imem_req=%b busy=%b expected 0/1", req_a, busy_a);
    end
    repeat (rv_dly) @(negedge clk);
    imem_rvalid = 1'b1;
    imem_rdata  = data;
    exp_ir_q.push_back(data);
    @(negedge clk);
    imem_rvalid = 1'b0;
    imem_rdata  = $urandom();
    checks++;
    if (done_a !== 1'b1 || busy_a !== 1'b0 || err_a !== 1'b0) begin
      errors++;
      $display("FAIL done_pulse: done=%b busy=%b err=%b expected 1/0/0", done_a, busy_a, err_a);
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (pc_a !== 32'h0 || ir_a !== 32'h13 || opcode_a !== 7'b0010011 || req_a !== 1'b0 ||
        busy_a !== 1'b0 || done_a !== 1'b0 || err_a !== 1'b0 || imm_i_a !== 32'h0 ||
        imm_u_a !== 32'h0 || rd_a !== 5'd0 || pc_w !== 32'hFFFF_FFFC) begin
      errors++;
      $display("FAIL reset_state: pc=%h ir=%h opc=%b req=%b busy=%b done=%b err=%b pc_w=%h",
               pc_a, ir_a, opcode_a, req_a, busy_a, done_a, err_a, pc_w);
    end
  endtask

  task automatic test_basic_fetch();
    do_fetch(0, 0, 32'h1234_5537);
    checks++;
    if (ir_a !== 32'h1234_5537 || opcode_a !== 7'b0110111 || rd_a !== 5'd10 ||
        imm_u_a !== 32'h1234_5000 || pc_a !== 32'd4) begin
      errors++;
      $display("FAIL basic_fields: ir=%h opc=%b rd=%0d imm_u=%h pc=%h expected 12345537/0110111/10/12345000/4",
               ir_a, opcode_a, rd_a, imm_u_a, pc_a);
    end
    @(negedge clk);
    checks++;
    if (done_a !== 1'b0) begin
      errors++;
      $display("FAIL done_single: done=%b expected 0", done_a);
    end
  endtask

  task automatic test_stalled();
    do_fetch(3, 2, 32'h0050_0113);
    @(negedge clk);
    checks++;
    if (done_a !== 1'b0 || imm_i_a !== 32'd5 || rd_a !== 5'd2) begin
      errors++;
      $display("FAIL stalled_after: done=%b imm_i=%h rd=%0d expected 0/5/2", done_a, imm_i_a, rd_a);
    end
  endtask

  task automatic test_back_to_back();
    do_fetch(0, 0, 32'h0020_81B3);
    checks++;
    if (opcode_a !== 7'b0110011 || rd_a !== 5'd3 || rs1_a !== 5'd1 || rs2_a !== 5'd2 ||
        funct7_a !== 7'd0 || funct3_a !== 3'd0) begin
      errors++;
      $display("FAIL add_fields: opc=%b rd=%0d rs1=%0d rs2=%0d f7=%b", opcode_a, rd_a, rs1_a, rs2_a, funct7_a);
    end
    do_fetch(1, 1, 32'h4020_8233);
    checks++;
    if (funct7_a !== 7'b0100000 || rd_a !== 5'd4 || rs1_a !== 5'd1 || rs2_a !== 5'd2) begin
      errors++;
      $display("FAIL sub_fields: f7=%b rd=%0d rs1=%0d rs2=%0d expected 0100000/4/1/2", funct7_a, rd_a, rs1_a, rs2_a);
    end
    @(negedge clk);
  endtask

  task automatic test_timeout();
    logic [31:0] pc0, ir0;
    int n;
    pc0 = pc_a;
    ir0 = ir_a;
    fetch_req = 1'b1;
    @(negedge clk);
    fetch_req = 1'b0;
    imem_gnt  = 1'b1;
    @(negedge clk);
    imem_gnt  = 1'b0;
    n = 0;
    while (err_a !== 1'b1 && n < 40) begin
      n++;
      @(negedge clk);
    end
    checks++;
    if (n != 15 || err_a !== 1'b1 || done_a !== 1'b0 || busy_a !== 1'b0) begin
      errors++;
      $display("FAIL timeout_len: wait cycles=%0d err=%b done=%b busy=%b expected 15/1/0/0", n, err_a, done_a, busy_a);
    end
    checks++;
    if (pc_a !== pc0 || ir_a !== ir0) begin
      errors++;
      $display("FAIL timeout_regs: pc=%h ir=%h expected %h %h", pc_a, ir_a, pc0, ir0);
    end
    imem_rvalid = 1'b1;
    imem_rdata  = 32'hDEAD_BEEF;
    @(negedge clk);
    imem_rvalid = 1'b0;
    @(negedge clk);
    checks++;
    if (err_a !== 1'b0 || done_a !== 1'b0 || ir_a !== ir0 || pc_a !== pc0 || busy_a !== 1'b0) begin
      errors++;
      $display("FAIL late_rvalid: err=%b done=%b ir=%h pc=%h busy=%b expected 0/0/%h/%h/0",
               err_a, done_a, ir_a, pc_a, busy_a, ir0, pc0);
    end
  endtask

  task automatic test_wrap_sign();
    do_reset();
    do_fetch(0, 0, 32'hFFF0_0093);
    checks++;
    if (pc_w !== 32'h0 || imm_i_w !== 32'hFFFF_FFFF || rd_w !== 5'd1 || funct3_w !== 3'd0 ||
        imm_i_a !== 32'hFFFF_FFFF || pc_a !== 32'd4) begin
      errors++;
      $display("FAIL wrap_sign: pc_w=%h imm_i_w=%h rd_w=%0d f3=%0d pc_a=%h expected 0/ffffffff/1/0/4",
               pc_w, imm_i_w, rd_w, funct3_w, pc_a);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_wait();
    fetch_req = 1'b1;
    @(negedge clk);
    fetch_req = 1'b0;
    imem_gnt  = 1'b1;
    @(negedge clk);
    imem_gnt  = 1'b0;
    rst_n     = 1'b0;
    #1;
    checks++;
    if (busy_a !== 1'b0 || pc_a !== 32'h0 || ir_a !== 32'h13 || pc_w !== 32'hFFFF_FFFC) begin
      errors++;
      $display("FAIL async_reset: busy=%b pc=%h ir=%h pc_w=%h expected 0/0/13/fffffffc", busy_a, pc_a, ir_a, pc_w);
    end
    @(negedge clk);
    rst_n    = 1'b1;
    exp_pc_a = 32'h0000_0000;
    exp_pc_w = 32'hFFFF_FFFC;
    exp_ir_q.delete();
    @(negedge clk);
    imem_rvalid = 1'b1;
    imem_rdata  = 32'h1234_5537;
    @(negedge clk);
    imem_rvalid = 1'b0;
    @(negedge clk);
    checks++;
    if (done_a !== 1'b0 || ir_a !== 32'h13 || pc_a !== 32'h0 || busy_a !== 1'b0) begin
      errors++;
      $display("FAIL reset_drop: done=%b ir=%h pc=%h busy=%b expected 0/13/0/0", done_a, ir_a, pc_a, busy_a);
    end
  endtask

  initial begin
    rst_n       = 1'b1;
    fetch_req   = 1'b0;
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata  = '0;
    exp_pc_a    = 32'h0000_0000;
    exp_pc_w    = 32'hFFFF_FFFC;
    test_reset();
    test_basic_fetch();
    test_stalled();
    test_back_to_back();
    test_timeout();
    test_wrap_sign();
    test_reset_mid_wait();
    repeat (2) @(negedge clk);
    checks++;
    if (exp_ir_q.size() != 0) begin
      errors++;
      $display("FAIL sb_drain: %0d entries left, expected 0", exp_ir_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
